// File: rtl/sram_read_arbiter_if.sv
// Voice request/response and SRAM pin bundle for the two-voice SRAM read arbiter.
// The arbiter takes the slave side; sequencers plus the SRAM pins form the master side.
interface sram_read_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              ack0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              ack1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    logic              busy;
    logic [ADDR_W-1:0] SRAM_A;
    logic [DATA_W-1:0] SRAM_D;
    logic              SRAM_CE;
    logic              SRAM_OE;
    logic              SRAM_WE;
    logic              SRAM_LB;
    logic              SRAM_UB;

    modport slave (
        input  req0, addr0, req1, addr1, SRAM_D,
        output ack0, rvalid0, rdata0, ack1, rvalid1, rdata1,
        output busy, SRAM_A, SRAM_CE, SRAM_OE, SRAM_WE, SRAM_LB, SRAM_UB
    );

    modport master (
        output req0, addr0, req1, addr1, SRAM_D,
        input  ack0, rvalid0, rdata0, ack1, rvalid1, rdata1,
        input  busy, SRAM_A, SRAM_CE, SRAM_OE, SRAM_WE, SRAM_LB, SRAM_UB
    );
endinterface

// File: rtl/sram_read_arbiter.sv
// Round-robin arbiter sharing one read-only SRAM port between two voices,
// with a fixed wait-state read: hold the address WAIT_CYCLES cycles, then sample SRAM_D.
module sram_read_arbiter #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    sram_read_arbiter_if.slave   bus
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("sram_read_arbiter: WAIT_CYCLES must be in 1..15");
    end

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t                  state, state_n;
    logic                    rr, rr_n;          // last granted voice, also the voice in flight
    logic [3:0]              cnt, cnt_n;
    logic [ADDR_W-1:0]       a_q, a_n;
    logic                    busy_q, busy_n;
    logic                    ce_q;
    logic [1:0]              ack_q, ack_n;
    logic [1:0]              rv_q, rv_n;
    logic [1:0][DATA_W-1:0]  rdata_q;
    logic [1:0]              req;
    logic [1:0][ADDR_W-1:0]  addr;
    logic                    win;

    assign req  = {bus.req1, bus.req0};
    assign addr = {bus.addr1, bus.addr0};
    // Under contention the voice not granted last goes next.
    assign win  = (req == 2'b11) ? ~rr : req[1];

    always_comb begin
        state_n = state;
        rr_n    = rr;
        cnt_n   = cnt;
        a_n     = a_q;
        busy_n  = busy_q;
        ack_n   = '0;
        rv_n    = '0;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    a_n        = addr[win];
                    ack_n[win] = 1'b1;
                    rr_n       = win;
                    cnt_n      = WAIT_INIT;
                    busy_n     = 1'b1;
                    state_n    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    rv_n[rr] = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_IDLE;
            rr     <= 1'b1;
            cnt    <= '0;
            a_q    <= '0;
            busy_q <= 1'b0;
            ce_q   <= 1'b1;
            ack_q  <= '0;
            rv_q   <= '0;
        end else begin
            state  <= state_n;
            rr     <= rr_n;
            cnt    <= cnt_n;
            a_q    <= a_n;
            busy_q <= busy_n;
            ce_q   <= ~busy_n;
            ack_q  <= ack_n;
            rv_q   <= rv_n;
        end
    end

    // Each voice's read data only moves on its own completion edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata_q <= '0;
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (rv_n[v]) rdata_q[v] <= bus.SRAM_D;
            end
        end
    end

    assign bus.ack0    = ack_q[0];
    assign bus.ack1    = ack_q[1];
    assign bus.rvalid0 = rv_q[0];
    assign bus.rvalid1 = rv_q[1];
    assign bus.rdata0  = rdata_q[0];
    assign bus.rdata1  = rdata_q[1];
    assign bus.busy    = busy_q;
    assign bus.SRAM_A  = a_q;
    assign bus.SRAM_CE = ce_q;
    assign bus.SRAM_OE = ce_q;
    assign bus.SRAM_WE = 1'b1;
    assign bus.SRAM_LB = 1'b0;
    assign bus.SRAM_UB = 1'b0;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Bench for sram_read_arbiter: directed table, hand-written corner sequences, and a
// randomized run against a transaction-level model, on WAIT_CYCLES=2 and =1 builds.
module tb_sram_read_arbiter;
    localparam int AW = 18;
    localparam int DW = 16;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #10 CLK = ~CLK;

    sram_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    sram_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    sram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) dut (
        .CLK(CLK), .RST(RST), .bus(bus0.slave));
    sram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut1 (
        .CLK(CLK), .RST(RST), .bus(bus1.slave));

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        if (a == 18'd5) return 16'hA3C1;
        return {a[7:0], ~a[7:0]};
    endfunction

    assign bus0.SRAM_D = mem(bus0.SRAM_A);
    assign bus1.SRAM_D = mem(bus1.SRAM_A);

    logic [59:0] obs0, obs1;
    assign obs0 = {bus0.ack0, bus0.ack1, bus0.rvalid0, bus0.rvalid1, bus0.busy, bus0.SRAM_CE,
                   bus0.SRAM_OE, bus0.SRAM_WE, bus0.SRAM_LB, bus0.SRAM_UB, bus0.SRAM_A,
                   bus0.rdata0, bus0.rdata1};
    assign obs1 = {bus1.ack0, bus1.ack1, bus1.rvalid0, bus1.rvalid1, bus1.busy, bus1.SRAM_CE,
                   bus1.SRAM_OE, bus1.SRAM_WE, bus1.SRAM_LB, bus1.SRAM_UB, bus1.SRAM_A,
                   bus1.rdata0, bus1.rdata1};

    function automatic logic [59:0] exp_vec(input logic a0, a1, v0, v1, b,
                                            input logic [AW-1:0] sa,
                                            input logic [DW-1:0] d0, d1);
        return {a0, a1, v0, v1, b, ~b, ~b, 1'b1, 1'b0, 1'b0, sa, d0, d1};
    endfunction

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic set0(input logic r0, r1, input logic [AW-1:0] a0, a1);
        bus0.req0 = r0; bus0.req1 = r1; bus0.addr0 = a0; bus0.addr1 = a1;
    endtask

    task automatic set1(input logic r0, r1, input logic [AW-1:0] a0, a1);
        bus1.req0 = r0; bus1.req1 = r1; bus1.addr0 = a0; bus1.addr1 = a1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    typedef struct {
        logic r0, r1;
        logic [AW-1:0] a0, a1;
        logic ea0, ea1, ev0, ev1, eb;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed0, ed1;
    } vec_t;
    vec_t tbl [14];

    // Transaction-level reference: one access at a time, timed from its grant cycle.
    int             g     [2];
    logic           gv    [2];
    logic           lastw [2];
    logic [AW-1:0]  ga    [2];
    logic [DW-1:0]  rdm   [2][2];
    int             wc    [2];
    logic           r0, r1, w;
    logic [AW-1:0]  a0, a1;
    logic [59:0]    e;
    int             acks, rvs, last_rv, nack1, nrv0;

    initial begin
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        #1 RST = 1'b1;
        #4;
        chk("reset_w2", 64'(obs0), 64'(exp_vec(0, 0, 0, 0, 0, 0, 0, 0)));
        chk("reset_w1", 64'(obs1), 64'(exp_vec(0, 0, 0, 0, 0, 0, 0, 0)));
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // single read of address 5, then both voices contending
        tbl[0]  = '{1, 0, 18'h5,  18'h0,  0, 0, 0, 0, 0, 18'h0,  16'h0,    16'h0};
        tbl[1]  = '{0, 0, 18'h5,  18'h0,  1, 0, 0, 0, 1, 18'h5,  16'h0,    16'h0};
        tbl[2]  = '{0, 0, 18'h0,  18'h0,  0, 0, 0, 0, 1, 18'h5,  16'h0,    16'h0};
        tbl[3]  = '{1, 1, 18'h10, 18'h20, 0, 0, 1, 0, 0, 18'h5,  16'hA3C1, 16'h0};
        tbl[4]  = '{1, 1, 18'h10, 18'h20, 0, 1, 0, 0, 1, 18'h20, 16'hA3C1, 16'h0};
        tbl[5]  = '{1, 1, 18'h10, 18'h20, 0, 0, 0, 0, 1, 18'h20, 16'hA3C1, 16'h0};
        tbl[6]  = '{1, 1, 18'h10, 18'h20, 0, 0, 0, 1, 0, 18'h20, 16'hA3C1, 16'h20DF};
        tbl[7]  = '{1, 1, 18'h10, 18'h20, 1, 0, 0, 0, 1, 18'h10, 16'hA3C1, 16'h20DF};
        tbl[8]  = '{1, 1, 18'h10, 18'h20, 0, 0, 0, 0, 1, 18'h10, 16'hA3C1, 16'h20DF};
        tbl[9]  = '{1, 1, 18'h10, 18'h20, 0, 0, 1, 0, 0, 18'h10, 16'h10EF, 16'h20DF};
        tbl[10] = '{0, 0, 18'h0,  18'h0,  0, 1, 0, 0, 1, 18'h20, 16'h10EF, 16'h20DF};
        tbl[11] = '{0, 0, 18'h0,  18'h0,  0, 0, 0, 0, 1, 18'h20, 16'h10EF, 16'h20DF};
        tbl[12] = '{0, 0, 18'h0,  18'h0,  0, 0, 0, 1, 0, 18'h20, 16'h10EF, 16'h20DF};
        tbl[13] = '{0, 0, 18'h0,  18'h0,  0, 0, 0, 0, 0, 18'h20, 16'h10EF, 16'h20DF};
        @(negedge CLK);
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("table_row%0d", i), 64'(obs0),
                64'(exp_vec(tbl[i].ea0, tbl[i].ea1, tbl[i].ev0, tbl[i].ev1, tbl[i].eb,
                            tbl[i].ea, tbl[i].ed0, tbl[i].ed1)));
            set0(tbl[i].r0, tbl[i].r1, tbl[i].a0, tbl[i].a1);
            @(negedge CLK);
        end

        // back-to-back voice 1, address bumped on each ack
        acks = 0; rvs = 0; last_rv = 0;
        set0(0, 1, 0, 0);
        for (int n = 0; n < 20; n++) begin
            if (bus0.rvalid1) begin
                chk("b2b_data", 64'(bus0.rdata1), 64'(mem(AW'(rvs))));
                if (rvs > 0) chk("b2b_spacing", 64'(n - last_rv), 64'd3);
                last_rv = n;
                rvs++;
            end
            if (bus0.ack1) begin
                acks++;
                if (acks == 4) bus0.req1 = 1'b0;
                else bus0.addr1 = bus0.addr1 + 1'b1;
            end
            @(negedge CLK);
        end
        chk("b2b_count", 64'(rvs), 64'd4);

        // reset in the cycle after ack0 aborts the access
        set0(1, 0, 18'h7, 0);
        @(negedge CLK);
        chk("rst_ack0", 64'(bus0.ack0), 64'd1);
        set0(0, 0, 0, 0);
        RST = 1'b1;
        #1;
        chk("rst_immediate", 64'(obs0), 64'(exp_vec(0, 0, 0, 0, 0, 0, 0, 0)));
        @(negedge CLK);
        chk("rst_held", 64'(obs0), 64'(exp_vec(0, 0, 0, 0, 0, 0, 0, 0)));
        RST = 1'b0;
        set0(1, 1, 18'h30, 18'h31);
        @(negedge CLK);
        chk("rst_first_grant", 64'(obs0), 64'(exp_vec(1, 0, 0, 0, 1, 18'h30, 0, 0)));
        set0(0, 0, 0, 0);
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_next_read", 64'(obs0), 64'(exp_vec(0, 0, 1, 0, 0, 18'h30, 16'h30CF, 0)));
        @(negedge CLK);

        // voice 1 pulses a request during voice 0's wait and withdraws it
        nack1 = 0; nrv0 = 0;
        set0(1, 0, 18'h9, 0);
        @(negedge CLK);
        chk("wd_ack0", 64'(bus0.ack0), 64'd1);
        set0(0, 1, 0, 18'h11);
        @(negedge CLK);
        nack1 += int'(bus0.ack1);
        bus0.req1 = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge CLK);
            nack1 += int'(bus0.ack1);
            nrv0  += int'(bus0.rvalid0);
            if (bus0.rvalid0) chk("wd_data", 64'(bus0.rdata0), 64'(mem(18'h9)));
        end
        chk("wd_no_ack1", 64'(nack1), 64'd0);
        chk("wd_one_rvalid0", 64'(nrv0), 64'd1);
        chk("wd_idle", 64'({bus0.busy, bus0.SRAM_CE}), 64'b01);

        // WAIT_CYCLES=1 build: two back-to-back reads of voice 0
        set1(1, 0, 18'h3, 0);
        @(negedge CLK);
        chk("w1_ack", 64'(obs1), 64'(exp_vec(1, 0, 0, 0, 1, 18'h3, 0, 0)));
        bus1.addr0 = 18'h4;
        @(negedge CLK);
        chk("w1_rvalid", 64'(obs1), 64'(exp_vec(0, 0, 1, 0, 0, 18'h3, 16'h03FC, 0)));
        @(negedge CLK);
        chk("w1_ack2", 64'(obs1), 64'(exp_vec(1, 0, 0, 0, 1, 18'h4, 16'h03FC, 0)));
        bus1.req0 = 1'b0;
        @(negedge CLK);
        chk("w1_rvalid2", 64'(obs1), 64'(exp_vec(0, 0, 1, 0, 0, 18'h4, 16'h04FB, 0)));
        @(negedge CLK);
        chk("w1_idle", 64'(obs1), 64'(exp_vec(0, 0, 0, 0, 0, 18'h4, 16'h04FB, 0)));

        // randomized traffic on both builds against the model
        do_reset();
        wc[0] = 2; wc[1] = 1;
        for (int k = 0; k < 2; k++) begin
            g[k] = -100; gv[k] = 1'b0; lastw[k] = 1'b1; ga[k] = '0;
            rdm[k][0] = '0; rdm[k][1] = '0;
        end
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (n == g[k] + 1 + wc[k]) rdm[k][gv[k]] = mem(ga[k]);
                e = exp_vec(n == g[k] + 1 && !gv[k], n == g[k] + 1 && gv[k],
                            n == g[k] + 1 + wc[k] && !gv[k], n == g[k] + 1 + wc[k] && gv[k],
                            n >= g[k] + 1 && n <= g[k] + wc[k], ga[k], rdm[k][0], rdm[k][1]);
                chk(k == 0 ? "rand_w2" : "rand_w1", 64'(k == 0 ? obs0 : obs1), 64'(e));
            end
            r0 = ($urandom_range(0, 9) < 4);
            r1 = ($urandom_range(0, 9) < 4);
            a0 = AW'($urandom_range(0, 31));
            a1 = AW'($urandom_range(0, 31));
            set0(r0, r1, a0, a1);
            set1(r0, r1, a0, a1);
            for (int k = 0; k < 2; k++) begin
                if (n >= g[k] + 1 + wc[k] && (r0 || r1)) begin
                    w        = (r0 && r1) ? !lastw[k] : r1;
                    g[k]     = n;
                    gv[k]    = w;
                    ga[k]    = w ? a1 : a0;
                    lastw[k] = w;
                end
            end
            @(negedge CLK);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/sram_read_arbiter.md
Name: sram_read_arbiter

Overview:
- Shares the single read-only SRAM port between two requesters: voice 0 (melody fetch) and voice 1 (harmony/second-voice fetch).
- Runs a fixed wait-state read sequence: drive address, hold for WAIT_CYCLES, sample SRAM_D, return data to the winner.
- Round-robin arbitration guarantees neither voice starves.
- Sits between the per-voice instruction sequencers and the external SRAM pins.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width.
- WAIT_CYCLES, 2, cycles the address is held before SRAM_D is sampled; legal range 1..15.

Ports:
- CLK  in  1  system clock, 50 MHz
- RST  in  1  asynchronous active-high reset
- req0  in  1  voice 0 read request (level)
- addr0  in  ADDR_W  voice 0 read address
- ack0  out  1  one-cycle pulse: voice 0 request accepted
- rvalid0  out  1  one-cycle pulse: rdata0 valid
- rdata0  out  DATA_W  voice 0 read data
- req1, addr1, ack1, rvalid1, rdata1  as above, for voice 1
- busy  out  1  high while an access is in flight (state WAIT)
- SRAM_A  out  ADDR_W  SRAM address
- SRAM_D  in  DATA_W  SRAM read data
- SRAM_CE  out  1  chip enable, active low
- SRAM_OE  out  1  output enable, active low
- SRAM_WE  out  1  write enable, active low; tied 1 (read-only)
- SRAM_LB, SRAM_UB  out  1  byte enables, active low; tied 0

Behaviour:
- Reset (async, RST=1) sets:
  - state=IDLE, rr pointer=1 (voice 0 wins first contention), counter=0;
  - ack0/1=0, rvalid0/1=0, rdata0/1=0, busy=0, SRAM_A=0, SRAM_CE=1, SRAM_OE=1.
- FSM has two states, IDLE and WAIT.
- IDLE:
  - Samples req0/req1.
  - Neither asserted: stay in IDLE.
  - Exactly one asserted: that voice wins.
  - Both asserted: the voice not granted last wins.
  - On the next edge:
    - register the winner's addr into SRAM_A;
    - pulse the winner's ack for one cycle;
    - set rr pointer to the winner, counter=WAIT_CYCLES;
    - set SRAM_CE=0, SRAM_OE=0, busy=1;
    - go to WAIT.
- WAIT:
  - Counter decrements each edge.
  - On the edge where counter==1:
    - capture SRAM_D into the winner's rdata;
    - pulse the winner's rvalid for one cycle;
    - set SRAM_CE=1, SRAM_OE=1, busy=0;
    - go to IDLE.
- Latency: request sampled in IDLE at cycle t:
  - ack high in cycle t+1;
  - SRAM_A stable in cycles t+1..t+WAIT_CYCLES;
  - rvalid high in cycle t+1+WAIT_CYCLES.
- Throughput: a new request can be sampled in the rvalid cycle, because state is already IDLE then. Minimum access period is WAIT_CYCLES+1 cycles.
- Handshake rules:
  - Requester holds req and addr stable until it sees ack.
  - req still high in the cycle after ack counts as a new request.
  - req dropped before being sampled in IDLE is never granted; it is not an error.
  - req and addr changes during WAIT are ignored.
- Per-voice outputs:
  - rdata of a voice changes only on that voice's rvalid edge and holds otherwise.
  - The other voice's rdata is untouched.
- SRAM_A holds the last address after an access completes; it is not cleared.
- Simultaneous events:
  - ack and rvalid are never high together for the same voice.
  - ack0 and ack1 are never high together.
  - rvalid0 and rvalid1 are never high together.
- Reset mid-WAIT aborts the access: no rvalid is produced and all registers return to reset values immediately.
- Width: counter is 4 bits. WAIT_CYCLES=0 or >15 is illegal; the implementation must flag it with an elaboration-time check.

Test Plan:
- Single read: RST released, req0=1, addr0=0x00005, SRAM model returns 0xA3C1 for address 5, WAIT_CYCLES=2. Required: ack0 in cycle t+1, SRAM_CE/OE low t+1..t+2, rvalid0 at t+3 with rdata0=0xA3C1, ack1/rvalid1 stay 0.
- Contention: req0 and req1 held high continuously, addr0=0x10, addr1=0x20. Required: grants alternate 0,1,0,1 with ack pulses every 3 cycles, and each rvalid carries data from its own address.
- Back-to-back single requester: req1 held high for 4 accesses, addr1 incremented on each ack1. Required: four rvalid1 pulses spaced 3 cycles apart, addresses 0..3 returned in order.
- Reset mid-access: RST asserted in the cycle after ack0. Required: no rvalid0 ever, outputs at reset values the same cycle, and the first grant after release goes to voice 0 under contention.
- WAIT_CYCLES=1 build: req0 at t. Required: ack0 at t+1, rvalid0 at t+2, SRAM_A stable exactly 1 cycle, access period 2 cycles.
- Withdrawn request: req1 pulsed for one cycle while state=WAIT serving voice 0, then dropped. Required: ack1 never asserted, arbiter idles after rvalid0.
